// File: rtl/reset_sequencer_if.sv
// Handshake bundle for the reset sequencer: start/ack/clear in, per-domain resets and status out.
// The master side drives start, acks and fault_clear; the slave side is the sequencer.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    localparam int FDW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic                   start;
    logic [NUM_DOMAINS-1:0] domain_ack;
    logic                   fault_clear;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   seq_done;
    logic                   seq_fault;
    logic [FDW-1:0]         fault_domain;
    logic [3:0]             retry_count;

    modport master (
        output start, domain_ack, fault_clear,
        input  domain_reset, seq_done, seq_fault, fault_domain, retry_count
    );

    modport slave (
        input  start, domain_ack, fault_clear,
        output domain_reset, seq_done, seq_fault, fault_domain, retry_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS resets one at a time, waiting for each domain's ack before
// moving on. An ack timeout latches a sticky fault; a lost start or ack aborts back to IDLE.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int STEP_DELAY  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              ext_clock,
    input  logic              system_areset,
    reset_sequencer_if.slave  bus
);
    localparam int FDW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int TMAX = (ACK_TIMEOUT > STEP_DELAY) ? ACK_TIMEOUT : STEP_DELAY;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, RELEASE, WAIT_ACK, GAP, DONE, ABORT, FAULT
    } state_t;

    state_t                 state, state_next;
    logic                   core_reset;
    logic [NUM_DOMAINS-1:0] ack_meta, ack_s;
    logic [FDW-1:0]         idx, idx_next;
    logic [TW-1:0]          timer, timer_next;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_next;
    logic                   seq_done_q, seq_fault_q;
    logic [FDW-1:0]         fault_domain_q, fault_domain_next;
    logic [3:0]             retry_q, retry_next;

    // Asserts with system_areset, drops on the first edge after release,
    // so the FSM makes its first decision on the second edge.
    always_ff @(posedge ext_clock or posedge system_areset) begin
        if (system_areset) core_reset <= 1'b1;
        else               core_reset <= 1'b0;
    end

    always_ff @(posedge ext_clock or posedge core_reset) begin
        if (core_reset) begin
            ack_meta <= '0;
            ack_s    <= '0;
        end else begin
            ack_meta <= bus.domain_ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge ext_clock or posedge core_reset) begin
        if (core_reset) begin
            state          <= IDLE;
            idx            <= '0;
            timer          <= '0;
            domain_reset_q <= '1;
            seq_done_q     <= 1'b0;
            seq_fault_q    <= 1'b0;
            fault_domain_q <= '0;
            retry_q        <= '0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            timer          <= timer_next;
            domain_reset_q <= domain_reset_next;
            seq_done_q     <= (state_next == DONE);
            seq_fault_q    <= (state_next == FAULT);
            fault_domain_q <= fault_domain_next;
            retry_q        <= retry_next;
        end
    end

    // A dropped start beats both ack and timeout; an ack beats a coincident timeout.
    always_comb begin
        state_next        = state;
        idx_next          = idx;
        timer_next        = timer;
        domain_reset_next = domain_reset_q;
        fault_domain_next = fault_domain_q;
        retry_next        = retry_q;
        case (state)
            IDLE: begin
                domain_reset_next = '1;
                idx_next          = '0;
                timer_next        = '0;
                if (bus.start) state_next = RELEASE;
            end
            RELEASE: begin
                if (!bus.start) begin
                    state_next        = ABORT;
                    domain_reset_next = '1;
                    timer_next        = '0;
                end else begin
                    domain_reset_next[idx] = 1'b0;
                    timer_next             = '0;
                    state_next             = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!bus.start) begin
                    state_next        = ABORT;
                    domain_reset_next = '1;
                    timer_next        = '0;
                end else if (ack_s[idx]) begin
                    timer_next = '0;
                    state_next = (idx == FDW'(NUM_DOMAINS - 1)) ? DONE : GAP;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_next        = FAULT;
                    domain_reset_next = '1;
                    timer_next        = '0;
                    fault_domain_next = idx;
                    retry_next        = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GAP: begin
                if (!bus.start) begin
                    state_next        = ABORT;
                    domain_reset_next = '1;
                    timer_next        = '0;
                end else if (timer == TW'(STEP_DELAY - 1)) begin
                    timer_next = '0;
                    idx_next   = idx + FDW'(1);
                    state_next = RELEASE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DONE: begin
                if (!bus.start || !(&ack_s)) begin
                    state_next        = ABORT;
                    domain_reset_next = '1;
                    timer_next        = '0;
                end
            end
            ABORT: begin
                domain_reset_next = '1;
                if (timer == TW'(STEP_DELAY - 1)) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            FAULT: begin
                domain_reset_next = '1;
                if (bus.fault_clear) state_next = IDLE;
            end
            default: begin
                state_next        = IDLE;
                domain_reset_next = '1;
            end
        endcase
    end

    assign bus.domain_reset = domain_reset_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.seq_fault    = seq_fault_q;
    assign bus.fault_domain = fault_domain_q;
    assign bus.retry_count  = retry_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (4 domains, 4-cycle gaps, 16-cycle ack timeout):
// a vector table for the main sequence plus hand-written abort, saturation and reset sequences.
module tb_reset_sequencer;
    logic ext_clock;
    logic system_areset;
    int   checks   = 0;
    int   failures = 0;
    logic both_seen = 1'b0;

    reset_sequencer_if #(.NUM_DOMAINS(4)) bus ();

    reset_sequencer #(
        .NUM_DOMAINS(4),
        .STEP_DELAY (4),
        .ACK_TIMEOUT(16)
    ) dut (
        .ext_clock    (ext_clock),
        .system_areset(system_areset),
        .bus          (bus)
    );

    typedef struct {
        string      name;
        logic       start;
        logic [3:0] ack;
        logic       clr;
        int         edges;
        logic [3:0] exp_dr;
        logic       exp_done;
        logic       exp_fault;
        logic [1:0] exp_fdom;
        logic [3:0] exp_retry;
    } vec_t;

    vec_t vecs[$];

    initial begin
        ext_clock = 1'b0;
        forever #5 ext_clock = ~ext_clock;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(negedge ext_clock) begin
        if (bus.seq_done && bus.seq_fault) both_seen <= 1'b1;
    end

    task automatic add_vec(input string name, input logic st, input logic [3:0] ack,
                           input logic clr, input int edges, input logic [3:0] dr,
                           input logic done, input logic fault, input logic [1:0] fdom,
                           input logic [3:0] retry);
        vec_t v;
        v.name = name; v.start = st; v.ack = ack; v.clr = clr; v.edges = edges;
        v.exp_dr = dr; v.exp_done = done; v.exp_fault = fault;
        v.exp_fdom = fdom; v.exp_retry = retry;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic st, input logic [3:0] ack, input logic clr,
                                  input int edges);
        bus.start       = st;
        bus.domain_ack  = ack;
        bus.fault_clear = clr;
        repeat (edges) @(posedge ext_clock);
        @(negedge ext_clock);
    endtask

    task automatic check_output(input string name, input logic [3:0] dr, input logic done,
                                input logic fault, input logic [1:0] fdom,
                                input logic [3:0] retry);
        checks++;
        if (bus.domain_reset !== dr || bus.seq_done !== done || bus.seq_fault !== fault ||
            bus.fault_domain !== fdom || bus.retry_count !== retry) begin
            failures++;
            $display("[TB] FAIL %s: got dr=%b done=%b fault=%b fdom=%0d retry=%0d, expected dr=%b done=%b fault=%b fdom=%0d retry=%0d",
                     name, bus.domain_reset, bus.seq_done, bus.seq_fault, bus.fault_domain,
                     bus.retry_count, dr, done, fault, fdom, retry);
        end
    endtask

    initial begin
        // Nominal sequence with acks returned shortly after each release, then abort from DONE,
        // resequence, timeout on domain 2, fault clear and a stray clear outside FAULT.
        add_vec("idle",          0, 4'b0000, 0, 3, 4'b1111, 0, 0, 0, 0);
        add_vec("release0",      1, 4'b0000, 0, 1, 4'b1111, 0, 0, 0, 0);
        add_vec("dr_1110",       1, 4'b0000, 0, 1, 4'b1110, 0, 0, 0, 0);
        add_vec("gap0_enter",    1, 4'b0001, 0, 3, 4'b1110, 0, 0, 0, 0);
        add_vec("gap0_end",      1, 4'b0001, 0, 4, 4'b1110, 0, 0, 0, 0);
        add_vec("dr_1100",       1, 4'b0001, 0, 1, 4'b1100, 0, 0, 0, 0);
        add_vec("gap1_enter",    1, 4'b0011, 0, 3, 4'b1100, 0, 0, 0, 0);
        add_vec("gap1_end",      1, 4'b0011, 0, 4, 4'b1100, 0, 0, 0, 0);
        add_vec("dr_1000",       1, 4'b0011, 0, 1, 4'b1000, 0, 0, 0, 0);
        add_vec("gap2_end",      1, 4'b0111, 0, 7, 4'b1000, 0, 0, 0, 0);
        add_vec("dr_0000",       1, 4'b0111, 0, 1, 4'b0000, 0, 0, 0, 0);
        add_vec("wait3",         1, 4'b1111, 0, 2, 4'b0000, 0, 0, 0, 0);
        add_vec("done",          1, 4'b1111, 0, 1, 4'b0000, 1, 0, 0, 0);
        add_vec("done_hold",     1, 4'b1111, 0, 5, 4'b0000, 1, 0, 0, 0);
        add_vec("ack1_drop_syn", 1, 4'b1101, 0, 2, 4'b0000, 1, 0, 0, 0);
        add_vec("abort_entry",   1, 4'b1101, 0, 1, 4'b1111, 0, 0, 0, 0);
        add_vec("abort_to_idle", 1, 4'b0000, 0, 4, 4'b1111, 0, 0, 0, 0);
        add_vec("reseq_release", 1, 4'b0000, 0, 1, 4'b1111, 0, 0, 0, 0);
        add_vec("reseq_dr_1110", 1, 4'b0000, 0, 1, 4'b1110, 0, 0, 0, 0);
        add_vec("reseq_dr_1100", 1, 4'b0011, 0, 8, 4'b1100, 0, 0, 0, 0);
        add_vec("reseq_dr_1000", 1, 4'b0011, 0, 6, 4'b1000, 0, 0, 0, 0);
        add_vec("wait2_last",    1, 4'b0011, 0, 15, 4'b1000, 0, 0, 0, 0);
        add_vec("timeout2",      1, 4'b0011, 0, 1, 4'b1111, 0, 1, 2, 1);
        add_vec("fault_sticky",  1, 4'b0011, 0, 5, 4'b1111, 0, 1, 2, 1);
        add_vec("fault_clear",   1, 4'b0011, 1, 1, 4'b1111, 0, 0, 2, 1);
        add_vec("idle_after",    0, 4'b0000, 0, 2, 4'b1111, 0, 0, 2, 1);
        add_vec("stray_clear",   0, 4'b0000, 1, 1, 4'b1111, 0, 0, 2, 1);

        system_areset   = 1'b1;
        bus.start       = 1'b0;
        bus.domain_ack  = 4'b0000;
        bus.fault_clear = 1'b0;
        repeat (3) @(posedge ext_clock);
        @(negedge ext_clock);
        check_output("reset_state", 4'b1111, 0, 0, 0, 0);
        system_areset = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].start, vecs[i].ack, vecs[i].clr, vecs[i].edges);
            check_output(vecs[i].name, vecs[i].exp_dr, vecs[i].exp_done, vecs[i].exp_fault,
                         vecs[i].exp_fdom, vecs[i].exp_retry);
        end

        // start falls in the very cycle ack_s[1] rises: abort must win, and the
        // next sequence must restart from domain 0.
        apply_stimulus(0, 4'b0001, 0, 3);
        check_output("race_idle", 4'b1111, 0, 0, 2, 1);
        apply_stimulus(1, 4'b0001, 0, 2);
        check_output("race_dr_1110", 4'b1110, 0, 0, 2, 1);
        apply_stimulus(1, 4'b0001, 0, 6);
        check_output("race_dr_1100", 4'b1100, 0, 0, 2, 1);
        apply_stimulus(1, 4'b0011, 0, 2);
        check_output("race_pre", 4'b1100, 0, 0, 2, 1);
        apply_stimulus(0, 4'b0011, 0, 1);
        check_output("race_abort", 4'b1111, 0, 0, 2, 1);
        apply_stimulus(0, 4'b0000, 0, 4);
        check_output("race_idle_back", 4'b1111, 0, 0, 2, 1);

        // Sixteen back-to-back timeouts on domain 0; retry_count saturates at 15.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_retry;
            exp_retry = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
            apply_stimulus(1, 4'b0000, 0, 18);
            check_output($sformatf("sat_fault_%0d", i), 4'b1111, 0, 1, 0, exp_retry);
            apply_stimulus(0, 4'b0000, 1, 1);
            check_output($sformatf("sat_clear_%0d", i), 4'b1111, 0, 0, 0, exp_retry);
        end

        // Asynchronous reset in the middle of the GAP after domain 1.
        apply_stimulus(0, 4'b0011, 0, 3);
        check_output("ar_idle", 4'b1111, 0, 0, 0, 15);
        apply_stimulus(1, 4'b0011, 0, 2);
        check_output("ar_dr_1110", 4'b1110, 0, 0, 0, 15);
        apply_stimulus(1, 4'b0011, 0, 8);
        check_output("ar_gap_idx1", 4'b1100, 0, 0, 0, 15);
        system_areset = 1'b1;
        #1;
        check_output("ar_async", 4'b1111, 0, 0, 0, 0);
        repeat (2) @(posedge ext_clock);
        @(negedge ext_clock);
        check_output("ar_held", 4'b1111, 0, 0, 0, 0);
        system_areset = 1'b0;
        apply_stimulus(1, 4'b0011, 0, 2);
        check_output("ar_release_2nd_edge", 4'b1111, 0, 0, 0, 0);
        apply_stimulus(1, 4'b0011, 0, 1);
        check_output("ar_release_dr_1110", 4'b1110, 0, 0, 0, 0);

        checks++;
        if (both_seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_fault_exclusive: got both_seen=%b, expected 0", both_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
